// File: rtl/fifo_pkg.sv
// Shared FIFO defaults, used by the synchronous controller and the async FIFO.
package fifo_pkg;
  localparam int DEF_ADDR_WIDTH = 4;
  localparam int DEF_RAM_HIGH   = 16;
  localparam int DEF_RAM_WIDTH  = 8;
endpackage

// File: rtl/ram.sv
// Simple dual-port RAM: independent write and read clocks, registered read data.
module ram
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int RAM_HIGH   = DEF_RAM_HIGH,
  parameter int RAM_WIDTH  = DEF_RAM_WIDTH
) (
  input  logic                  w_clk,
  input  logic                  en_write,
  input  logic [ADDR_WIDTH-1:0] w_addr,
  input  logic [RAM_WIDTH-1:0]  w_data,
  input  logic                  r_clk,
  input  logic                  en_read,
  input  logic [ADDR_WIDTH-1:0] r_addr,
  output logic [RAM_WIDTH-1:0]  r_data
);

  logic [RAM_WIDTH-1:0] mem [RAM_HIGH];

  always_ff @(posedge w_clk) begin
    if (en_write) mem[w_addr] <= w_data;
  end

  // r_data only moves on en_read, which keeps the FIFO output word stable under backpressure
  always_ff @(posedge r_clk) begin
    if (en_read) r_data <= mem[r_addr];
  end

endmodule

// File: rtl/fifo_ctrl.sv
// First-word-fall-through FIFO controller around one dual-port ram; the RAM read
// register doubles as the output word, so capacity is RAM_HIGH+1.
module fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int RAM_HIGH    = DEF_RAM_HIGH,
  parameter int RAM_WIDTH   = DEF_RAM_WIDTH,
  parameter int AFULL_LEVEL = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [RAM_WIDTH-1:0]  s_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [RAM_WIDTH-1:0]  m_data,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  empty,
  output logic                  almost_full
);

  localparam logic [ADDR_WIDTH:0] FULL_CNT  = (ADDR_WIDTH+1)'(RAM_HIGH);
  localparam logic [ADDR_WIDTH:0] AFULL_CNT = (ADDR_WIDTH+1)'(AFULL_LEVEL);

  logic [ADDR_WIDTH-1:0] wptr;
  logic [ADDR_WIDTH-1:0] rptr;
  logic [ADDR_WIDTH:0]   mem_cnt;
  logic [ADDR_WIDTH:0]   level_q;
  logic                  vld_p1;

  logic                  clr;
  logic                  push;
  logic                  fetch;
  logic                  pop;
  logic                  en_write;
  logic                  en_read;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [ADDR_WIDTH-1:0] r_addr;

  assign s_ready = (mem_cnt != FULL_CNT);

  // Stage p0: handshake decode; m_ready reaches en_read combinationally for full throughput
  always_comb begin
    clr      = rst | flush;
    push     = s_valid & s_ready & ~clr;
    fetch    = (mem_cnt != '0) & (~vld_p1 | m_ready) & ~clr;
    pop      = vld_p1 & m_ready;
    en_write = push;
    w_addr   = wptr;
    en_read  = fetch;
    r_addr   = rptr;
  end

  // Stage p1: pointers, counts and the output-word valid
  always_ff @(posedge clk) begin
    if (clr) begin
      wptr    <= '0;
      rptr    <= '0;
      mem_cnt <= '0;
      level_q <= '0;
      vld_p1  <= 1'b0;
    end else begin
      if (push)  wptr <= wptr + ADDR_WIDTH'(1);
      if (fetch) rptr <= rptr + ADDR_WIDTH'(1);
      mem_cnt <= mem_cnt + (ADDR_WIDTH+1)'(push) - (ADDR_WIDTH+1)'(fetch);
      level_q <= level_q + (ADDR_WIDTH+1)'(push) - (ADDR_WIDTH+1)'(pop);
      if (fetch)    vld_p1 <= 1'b1;
      else if (pop) vld_p1 <= 1'b0;
    end
  end

  assign m_valid     = vld_p1;
  assign level       = level_q;
  assign empty       = (level_q == '0);
  assign almost_full = (level_q >= AFULL_CNT);

  ram #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .RAM_HIGH   (RAM_HIGH),
    .RAM_WIDTH  (RAM_WIDTH)
  ) u_ram (
    .w_clk    (clk),
    .en_write (en_write),
    .w_addr   (w_addr),
    .w_data   (s_data),
    .r_clk    (clk),
    .en_read  (en_read),
    .r_addr   (r_addr),
    .r_data   (m_data)
  );

endmodule

// File: tb/tb_fifo_ctrl.sv
// Bench for fifo_ctrl: vector table, hand-written corner sequences, and a random run
// against a queue-level model of the FIFO.
module tb_fifo_ctrl;
  localparam int AW = 4;
  localparam int RH = 16;
  localparam int RW = 8;
  localparam int AF = 12;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [RW-1:0] s_data = '0;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [RW-1:0] m_data;
  logic [AW:0]   level;
  logic          empty;
  logic          almost_full;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fifo_ctrl #(
    .ADDR_WIDTH  (AW),
    .RAM_HIGH    (RH),
    .RAM_WIDTH   (RW),
    .AFULL_LEVEL (AF)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_data      (s_data),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_data      (m_data),
    .level       (level),
    .empty       (empty),
    .almost_full (almost_full)
  );

  typedef struct {
    logic          rst;
    logic          flush;
    logic          sv;
    logic [RW-1:0] sd;
    logic          mr;
    logic          e_sr;
    logic          e_mv;
    logic [RW-1:0] e_md;
    int            e_lvl;
    logic          e_emp;
    logic          e_af;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; flush = 1'b0; s_valid = 1'b0; m_ready = 1'b0;
    step();
    rst = 1'b0;
  endtask

  function automatic vec_t mk(logic r, logic f, logic sv, logic [RW-1:0] sd, logic mr,
                              logic e_sr, logic e_mv, logic [RW-1:0] e_md, int e_lvl,
                              logic e_emp, logic e_af);
    vec_t v;
    v.rst = r; v.flush = f; v.sv = sv; v.sd = sd; v.mr = mr;
    v.e_sr = e_sr; v.e_mv = e_mv; v.e_md = e_md; v.e_lvl = e_lvl;
    v.e_emp = e_emp; v.e_af = e_af;
    return v;
  endfunction

  // queue-level reference model
  logic [RW-1:0] mq[$];
  logic          mdl_vld;
  logic [RW-1:0] mdl_word;

  task automatic model_edge(input logic f, input logic sv, input logic [RW-1:0] sd, input logic mr);
    logic rdy;
    logic do_push;
    logic do_fetch;
    rdy = (mq.size() != RH);
    if (f) begin
      mq.delete();
      mdl_vld = 1'b0;
    end else begin
      do_push  = sv && rdy;
      do_fetch = (mq.size() != 0) && (!mdl_vld || mr);
      if (do_fetch) begin
        mdl_word = mq.pop_front();
        mdl_vld  = 1'b1;
      end else if (mdl_vld && mr) begin
        mdl_vld = 1'b0;
      end
      if (do_push) mq.push_back(sd);
    end
  endtask

  initial begin
    int sent;
    int got;
    int first_c;
    int last_c;
    logic pushed;
    int lvl;

    do_reset();
    do_reset();

    // reset then idle
    step();
    chk("rst_s_ready", s_ready, 1);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_level", level, 0);
    chk("rst_empty", empty, 1);
    chk("rst_afull", almost_full, 0);
    chk("rst_en_write", dut.en_write, 0);
    chk("rst_en_read", dut.en_read, 0);

    // single word, then flush mid-stream with a concurrent push
    //             rst flush sv  sd     mr   sr   mv  md     lvl emp  af
    tbl.push_back(mk(1, 0, 0, 8'h00, 1,   1, 0, 8'h00, 0, 1, 0));
    tbl.push_back(mk(0, 0, 1, 8'hA5, 1,   1, 0, 8'h00, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 8'h00, 1,   1, 1, 8'hA5, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 8'h00, 1,   1, 0, 8'h00, 0, 1, 0));
    tbl.push_back(mk(0, 0, 1, 8'h11, 0,   1, 0, 8'h00, 1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 8'h12, 0,   1, 1, 8'h11, 2, 0, 0));
    tbl.push_back(mk(0, 0, 1, 8'h13, 0,   1, 1, 8'h11, 3, 0, 0));
    tbl.push_back(mk(0, 0, 1, 8'h14, 0,   1, 1, 8'h11, 4, 0, 0));
    tbl.push_back(mk(0, 0, 1, 8'h15, 0,   1, 1, 8'h11, 5, 0, 0));
    tbl.push_back(mk(0, 1, 1, 8'h99, 0,   1, 0, 8'h00, 0, 1, 0));
    tbl.push_back(mk(0, 0, 1, 8'h3C, 1,   1, 0, 8'h00, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 8'h00, 0,   1, 1, 8'h3C, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 8'h00, 1,   1, 0, 8'h00, 0, 1, 0));

    foreach (tbl[i]) begin
      rst = tbl[i].rst; flush = tbl[i].flush; s_valid = tbl[i].sv;
      s_data = tbl[i].sd; m_ready = tbl[i].mr;
      step();
      chk($sformatf("vec%0d_s_ready", i), s_ready, tbl[i].e_sr);
      chk($sformatf("vec%0d_m_valid", i), m_valid, tbl[i].e_mv);
      if (tbl[i].e_mv) chk($sformatf("vec%0d_m_data", i), m_data, tbl[i].e_md);
      chk($sformatf("vec%0d_level", i), level, tbl[i].e_lvl);
      chk($sformatf("vec%0d_empty", i), empty, tbl[i].e_emp);
      chk($sformatf("vec%0d_afull", i), almost_full, tbl[i].e_af);
    end
    flush = 1'b0;

    // fill to RAM_HIGH+1 with the consumer stalled
    do_reset();
    m_ready = 1'b0;
    for (int k = 0; k <= RH; k++) begin
      s_valid = 1'b1;
      s_data  = k[RW-1:0];
      step();
      chk($sformatf("fill%0d_level", k), level, k + 1);
      chk($sformatf("fill%0d_afull", k), almost_full, (k + 1) >= AF);
    end
    chk("fill_s_ready_low", s_ready, 0);
    s_data = 8'hEE;
    step();
    chk("fill_overrun_level", level, RH + 1);
    chk("fill_overrun_s_ready", s_ready, 0);
    chk("fill_head_word", m_data, 0);
    s_valid = 1'b0;
    m_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 3 * RH; c++) begin
      if (m_valid) begin
        chk($sformatf("drain%0d_data", got), m_data, got);
        got++;
      end
      step();
    end
    chk("drain_count", got, RH + 1);
    chk("drain_empty", empty, 1);

    // continuous stream through the pointer wrap
    do_reset();
    m_ready = 1'b1;
    sent = 0; got = 0; first_c = -1; last_c = -1;
    for (int c = 0; c < 60; c++) begin
      s_valid = (sent < 40);
      s_data  = sent[RW-1:0];
      if (m_valid) begin
        chk($sformatf("wrap%0d_data", got), m_data, got);
        if (first_c < 0) first_c = c;
        last_c = c;
        got++;
      end
      pushed = s_valid && s_ready;
      step();
      if (pushed) sent++;
    end
    s_valid = 1'b0;
    chk("wrap_count", got, 40);
    chk("wrap_latency", first_c, 2);
    chk("wrap_throughput", last_c - first_c, 39);

    // backpressure: 8 words queued, then random consumer and producer against the model
    do_reset();
    mq.delete();
    mdl_vld = 1'b0;
    mdl_word = '0;
    for (int c = 0; c < 8; c++) begin
      s_valid = 1'b1; s_data = RW'($urandom); m_ready = 1'b0; flush = 1'b0;
      model_edge(flush, s_valid, s_data, m_ready);
      step();
    end
    for (int c = 0; c < 1500; c++) begin
      lvl = mq.size() + int'(mdl_vld);
      chk("rnd_s_ready", s_ready, mq.size() != RH);
      chk("rnd_m_valid", m_valid, mdl_vld);
      if (mdl_vld) chk("rnd_m_data", m_data, mdl_word);
      chk("rnd_level", level, lvl);
      chk("rnd_empty", empty, lvl == 0);
      chk("rnd_afull", almost_full, lvl >= AF);
      s_valid = (c < 40) ? 1'b0 : (($urandom % 4) != 0);
      s_data  = RW'($urandom);
      m_ready = ($urandom % 2) == 0;
      flush   = (c > 100) && (($urandom % 97) == 0);
      model_edge(flush, s_valid, s_data, m_ready);
      step();
    end
    flush = 1'b0; s_valid = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_ctrl.md
# fifo_ctrl

Single-clock FIFO controller that sequences the team's dual-port `ram` block as a first-word-fall-through queue. It owns the write and read pointers, the occupancy count and the full/empty/almost flags. It drives the RAM's `en_write`/`w_addr`/`en_read`/`r_addr` and exposes valid/ready handshakes on both sides. It sits between a producer and a consumer in the same clock domain and instantiates one `ram` with both RAM clocks tied to `clk`.

## Interface
- `ADDR_WIDTH`, default 4: RAM address width.
- `RAM_HIGH`, default 16: RAM depth; must equal 2**`ADDR_WIDTH`.
- `RAM_WIDTH`, default 8: data width.
- `AFULL_LEVEL`, default 12: `almost_full` threshold, 1..`RAM_HIGH`.

Ports:
- `clk` in 1: single clock. Both RAM clock inputs are tied to `clk`.
- `rst` in 1: reset, synchronous and active-high.
- `flush` in 1: synchronous clear of queue contents. Same effect as `rst` on pointers and flags.
- `s_valid` in 1: producer has data.
- `s_ready` out 1: controller accepts data.
- `s_data` in `RAM_WIDTH`: producer data, forwarded to the RAM `w_data`.
- `m_valid` out 1: output word is valid.
- `m_ready` in 1: consumer accepts the word.
- `m_data` out `RAM_WIDTH`: the RAM `r_data`, passed through.
- `level` out `ADDR_WIDTH+1`: total entries held, counting RAM entries plus the output word.
- `empty` out 1: `level == 0`.
- `almost_full` out 1: `level >= AFULL_LEVEL`.

## Operation
- Pointers `wptr` and `rptr` are `ADDR_WIDTH` bits and wrap modulo `RAM_HIGH`. `mem_cnt` (`ADDR_WIDTH+1` bits) is the number of entries written and not yet fetched.
- Push: `push = s_valid & s_ready`, with `s_ready = (mem_cnt != RAM_HIGH)`, combinational from registers. On push: `en_write=1`, `w_addr=wptr`, `wptr++`.
- Fetch: `fetch = (mem_cnt != 0) & (!m_valid | m_ready)`. On fetch: `en_read=1`, `r_addr=rptr`, `rptr++`. `m_valid` is set on the next edge.
- Pop: `pop = m_valid & m_ready`. If pop occurs without fetch, `m_valid` clears next edge.
- `m_data` is stable while `m_valid & !m_ready`, because the RAM output register only updates on `en_read`.
- `mem_cnt` next value is `mem_cnt + push - fetch`. `level` next value is `level + push - pop`. Both are registered.
- Simultaneous push and fetch are always legal. The two addresses never collide: fetch requires an occupied entry and push requires a free one.
- Push into an empty controller and fetch in the same cycle is impossible, because fetch sees `mem_cnt==0`. There is no bypass path.
- Producer stall: if `s_valid` is high while `s_ready` is low, nothing is written and `s_data` is ignored.
- `rst` or `flush` clears on the next edge: `wptr=rptr=0`, `mem_cnt=0`, `level=0`, `m_valid=0`. RAM contents are not cleared. Any push or pop presented in the same cycle is discarded. `rst` takes priority; `flush` takes the same action.

## Timing
- Values after reset: `s_ready=1`, `m_valid=0`, `level=0`, `empty=1`, `almost_full=0`, `en_write=0`, `en_read=0`.
- First-word latency: push at edge N, then fetch during cycle N to N+1, then `m_valid=1` after edge N+1. That is 2 edges from push to visible output.
- Steady state: with `m_ready` held high and at least 1 entry buffered, one word per cycle.
- `s_ready` deasserts in the cycle after the push that made `mem_cnt==RAM_HIGH`. Total capacity is `RAM_HIGH+1` words, because the output word is held outside the RAM.
- A fetch in the full state reasserts `s_ready` on the following cycle. A push and fetch in the same cycle while full is not possible.
- Flags are registered or derived from registered counts only. There are no combinational paths from `m_ready` or `s_valid` to `s_ready`.
- The path from `m_ready` to `en_read` is combinational. This is intentional, to allow full throughput.

## Structure
- Shared package `fifo_pkg` holds the default `ADDR_WIDTH`, `RAM_HIGH` and `RAM_WIDTH` constants. The async FIFO reuses them.
- One sub-module: `ram`, instantiated as `u_ram`, with `w_clk=r_clk=clk`.
- The controller logic (pointers, counts, `m_valid`) lives in `fifo_ctrl` itself. There is no further hierarchy.

## Test plan
- Reset then idle:
  - Required: `s_ready=1`, `m_valid=0`, `level=0`, `empty=1`, and no RAM enables.
- Single word:
  - Stimulus: push `0xA5` at edge 1, with `m_ready=1`.
  - Required: `m_valid=1` and `m_data=0xA5` after edge 2, then `m_valid=0` after edge 3, `level` back to 0.
- Fill:
  - Stimulus: push `0x00..0x10` (17 words) with `m_ready=0`.
  - Required: `s_ready=0` after the 17th push, `level=17`, and `almost_full=1` from `level=12` onward.
  - Follow-up: an 18th `s_valid` is not written. Draining then yields `0x00..0x10` in order.
- Wrap-around:
  - Stimulus: stream 40 incrementing words with `s_valid=m_ready=1` continuously.
  - Required: output order matches input exactly, with one word per cycle after the 2-cycle latency.
- Backpressure:
  - Stimulus: toggle `m_ready` randomly with 8 words queued.
  - Required: `m_data` is held constant while `m_valid & !m_ready`, and no word is lost or duplicated.
- Flush mid-stream:
  - Stimulus: with `level=5`, assert `flush` together with a push.
  - Required: next cycle `level=0`, `m_valid=0`, `empty=1`. The next push of `0x3C` appears at the output 2 edges later.
